// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-addressed data memory.
// Byte/half stores become a stalled read-modify-write pair; misaligned accesses are dropped and counted.
module lsu_subword #(
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   st,
  input  logic [1:0]             size,
  input  logic                   uns,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   stall,
  output logic                   fault,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  output logic                   mem_we,
  output logic [31:0]            mem_a,
  output logic [31:0]            mem_wd,
  input  logic [31:0]            mem_rd
);

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                 state_r;
  logic [31:0]            addr_q_r;
  logic [31:0]            merge_q_r;
  logic [FAULT_CNT_W-1:0] fault_cnt_r;

  logic        is_word_s;
  logic        is_half_s;
  logic        misalign_s;
  logic [31:0] word_a_s;
  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;
  logic [31:0] ld_data_s;

  // Replace the addressed byte or halfword lane of old_w with the low bits of new_d.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_d,
                                              input logic half, input logic [1:0] off);
    logic [31:0] m;
    m = old_w;
    if (half) begin
      if (off[1]) m[31:16] = new_d[15:0];
      else        m[15:0]  = new_d[15:0];
    end else begin
      case (off)
        2'b00:   m[7:0]   = new_d[7:0];
        2'b01:   m[15:8]  = new_d[7:0];
        2'b10:   m[23:16] = new_d[7:0];
        2'b11:   m[31:24] = new_d[7:0];
        default: m        = old_w;
      endcase
    end
    return m;
  endfunction

  assign is_word_s  = size[1];
  assign is_half_s  = (size == 2'b01);
  assign misalign_s = (is_half_s & addr[0]) | (is_word_s & (addr[1:0] != 2'b00));
  assign word_a_s   = {addr[31:2], 2'b00};
  assign fault      = req & misalign_s & (state_r == IDLE);
  assign fault_cnt  = fault_cnt_r;

  // Lane selection and sign/zero extension of the load result.
  always_comb begin
    lane_b_s  = 8'h00;
    ld_data_s = mem_rd;
    case (addr[1:0])
      2'b00:   lane_b_s = mem_rd[7:0];
      2'b01:   lane_b_s = mem_rd[15:8];
      2'b10:   lane_b_s = mem_rd[23:16];
      2'b11:   lane_b_s = mem_rd[31:24];
      default: lane_b_s = 8'h00;
    endcase
    lane_h_s = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size)
      2'b00:   ld_data_s = uns ? {24'h000000, lane_b_s} : {{24{lane_b_s[7]}}, lane_b_s};
      2'b01:   ld_data_s = uns ? {16'h0000, lane_h_s} : {{16{lane_h_s[15]}}, lane_h_s};
      default: ld_data_s = mem_rd;
    endcase
  end

  // Core-side and memory-side outputs; reset forces the write and stall off in the same cycle.
  always_comb begin
    mem_we = 1'b0;
    stall  = 1'b0;
    rdata  = 32'h0000_0000;
    mem_a  = word_a_s;
    mem_wd = wdata;
    if (reset) begin
      mem_we = 1'b0;
    end else if (state_r == WRITE) begin
      mem_a  = addr_q_r;
      mem_wd = merge_q_r;
      mem_we = 1'b1;
    end else if (req && !misalign_s) begin
      if (st) begin
        if (is_word_s) mem_we = 1'b1;
        else           stall  = 1'b1;
      end else begin
        rdata = ld_data_s;
      end
    end else begin
      mem_we = 1'b0;
    end
  end

  // RMW sequencer and saturating misalignment counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_q_r    <= 32'h0000_0000;
      merge_q_r   <= 32'h0000_0000;
      fault_cnt_r <= {FAULT_CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req && misalign_s) begin
            if (fault_cnt_r != {FAULT_CNT_W{1'b1}})
              fault_cnt_r <= fault_cnt_r + {{(FAULT_CNT_W-1){1'b0}}, 1'b1};
            else
              fault_cnt_r <= fault_cnt_r;
          end else if (req && st && !is_word_s) begin
            addr_q_r  <= word_a_s;
            merge_q_r <= merge_lanes(mem_rd, wdata, is_half_s, addr[1:0]);
            state_r   <= WRITE;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Randomised and directed bench for lsu_subword against a transaction-level memory model.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, st, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic        stall, fault, mem_we;
  logic [7:0]  fault_cnt;

  lsu_subword #(.FAULT_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .st(st), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .fault_cnt(fault_cnt), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT, and the model's view of what it should hold.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk = 1'b0;
  int          ref_cnt = 0;
  logic [31:0] exp_rdata, exp_a, exp_wd, exp_cnt, last_rdata;
  logic        exp_stall, exp_we, exp_fault;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model expectation.
  always @(negedge clk) begin
    if (chk) begin
      check("rdata", rdata, exp_rdata);
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      check("fault", {31'd0, fault}, {31'd0, exp_fault});
      check("fault_cnt", {24'd0, fault_cnt}, exp_cnt);
      check("mem_a", mem_a, exp_a);
      if (exp_we) check("mem_wd", mem_wd, exp_wd);
      last_rdata = rdata;
    end
  end

  task automatic set_idle_exp();
    exp_rdata = 32'd0; exp_stall = 1'b0; exp_we = 1'b0; exp_fault = 1'b0;
    exp_a = addr & ~32'd3; exp_wd = 32'd0; exp_cnt = ref_cnt;
  endtask

  // Drive one access starting just after a rising edge; model its effects from the ISA rules.
  task automatic access(input bit s, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd);
    int          idx;
    int          off;
    bit          mis;
    logic [31:0] w, v, mask, merged;
    idx  = int'(a[7:2]);
    off  = int'(a[1:0]);
    w    = ref_mem[idx];
    mis  = (sz == 2'b01 && a[0]) || (sz[1] && off != 0);
    mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (sz == 2'b00) ? ((w >> (8 * off)) & mask) : ((w >> (16 * (off / 2))) & mask);
    if (sz == 2'b00 && !u && v[7])  v = v | 32'hFFFF_FF00;
    if (sz == 2'b01 && !u && v[15]) v = v | 32'hFFFF_0000;
    if (sz[1]) v = w;
    merged = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    req = 1'b1; st = s; size = sz; uns = u; addr = a; wdata = wd;
    exp_fault = mis;
    exp_cnt   = ref_cnt;
    exp_stall = !mis && s && !sz[1];
    exp_we    = !mis && s && sz[1];
    exp_wd    = wd;
    exp_a     = a & ~32'd3;
    exp_rdata = (!mis && !s) ? v : 32'd0;
    chk = 1'b1;
    @(posedge clk); #1;
    if (mis) begin
      ref_cnt = (ref_cnt < 255) ? ref_cnt + 1 : 255;
    end else if (s && sz[1]) begin
      ref_mem[idx] = wd;
    end else if (s) begin
      exp_stall = 1'b0; exp_we = 1'b1; exp_wd = merged; exp_fault = 1'b0; exp_rdata = 32'd0;
      @(posedge clk); #1;
      ref_mem[idx] = merged;
    end
    req = 1'b0;
    set_idle_exp();
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; st = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8] = 32'h1122_3344;  ref_mem[8] = 32'h1122_3344;
    mem[12] = 32'h8001_F0FF; ref_mem[12] = 32'h8001_F0FF;
    mem[20] = 32'hCAFE_BABE; ref_mem[20] = 32'hCAFE_BABE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_cnt", {24'd0, fault_cnt}, 32'd0);
    reset = 1'b0;
    set_idle_exp();
    chk = 1'b1;

    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_10", last_rdata, 32'hDEAD_BEEF);
    access(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AB);
    check("sb_22_mem", mem[8], 32'h11AB_3344);
    access(1'b0, 2'b00, 1'b1, 32'h22, 32'h0);
    check("lbu_22", last_rdata, 32'h0000_00AB);
    access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
    check("lb_30", last_rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'b00, 1'b1, 32'h30, 32'h0);
    check("lbu_30", last_rdata, 32'h0000_00FF);
    access(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("lh_32", last_rdata, 32'hFFFF_8001);
    access(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    check("lhu_32", last_rdata, 32'h0000_8001);
    access(1'b1, 2'b01, 1'b0, 32'h41, 32'h5555_AAAA);
    access(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
    check("cnt_two", {24'd0, fault_cnt}, 32'd2);

    for (int i = 0; i < 250; i++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 255);
      if (ra[7:2] == 6'd20) ra = ra ^ 32'h40;
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ra, $urandom);
    end

    for (int i = 0; i < 300; i++) access(1'b0, 2'b10, 1'b0, 32'h43, 32'h0);
    check("cnt_sat", {24'd0, fault_cnt}, 32'd255);

    // Reset landing in the write half of a byte RMW must discard the write.
    chk = 1'b0;
    req = 1'b1; st = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h50; wdata = 32'h77;
    @(posedge clk); #1;
    check("rmw_write_phase", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rmw_rst_we", {31'd0, mem_we}, 32'd0);
    check("rmw_rst_stall", {31'd0, stall}, 32'd0);
    check("rmw_rst_cnt", {24'd0, fault_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    ref_cnt = 0;
    check("rmw_rst_mem", mem[20], 32'hCAFE_BABE);
    set_idle_exp();
    chk = 1'b1;
    access(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    check("lw_50", last_rdata, 32'hCAFE_BABE);

    // Reset during an idle word store suppresses the write.
    chk = 1'b0;
    req = 1'b1; st = 1'b1; size = 2'b10; addr = 32'h60; wdata = 32'h1234_5678;
    reset = 1'b1;
    #1;
    check("wst_rst_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    check("wst_rst_mem", mem[24], ref_mem[24]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
